// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_pkg
// Brief    : Shared encodings for the hardwired control sequencer: state
//            codes, instruction classes, opcode and ALU-op constants.
// Revision : 1.0
// ============================================================================
package control_pkg;

    // T-step states sit at their own T number so tstate is a direct copy.
    localparam int unsigned c_STATE_W = 4;
    localparam logic [c_STATE_W-1:0] c_ST_T0    = 4'd0;
    localparam logic [c_STATE_W-1:0] c_ST_T1    = 4'd1;
    localparam logic [c_STATE_W-1:0] c_ST_T2    = 4'd2;
    localparam logic [c_STATE_W-1:0] c_ST_T3    = 4'd3;
    localparam logic [c_STATE_W-1:0] c_ST_T4    = 4'd4;
    localparam logic [c_STATE_W-1:0] c_ST_T5    = 4'd5;
    localparam logic [c_STATE_W-1:0] c_ST_T6    = 4'd6;
    localparam logic [c_STATE_W-1:0] c_ST_T7    = 4'd7;
    localparam logic [c_STATE_W-1:0] c_ST_RESET = 4'd14;
    localparam logic [c_STATE_W-1:0] c_ST_HALT  = 4'd15;

    localparam int unsigned c_CLASS_W = 3;
    localparam logic [c_CLASS_W-1:0] c_CL_NOP   = 3'd0;
    localparam logic [c_CLASS_W-1:0] c_CL_RTYPE = 3'd1;
    localparam logic [c_CLASS_W-1:0] c_CL_IMM   = 3'd2;
    localparam logic [c_CLASS_W-1:0] c_CL_LD    = 3'd3;
    localparam logic [c_CLASS_W-1:0] c_CL_ST    = 3'd4;
    localparam logic [c_CLASS_W-1:0] c_CL_BR    = 3'd5;
    localparam logic [c_CLASS_W-1:0] c_CL_HALT  = 3'd6;

    localparam logic [4:0] c_OP_RTYPE_LO = 5'b00011;
    localparam logic [4:0] c_OP_RTYPE_HI = 5'b01011;
    localparam logic [4:0] c_OP_ADDI     = 5'b01100;
    localparam logic [4:0] c_OP_ANDI     = 5'b01101;
    localparam logic [4:0] c_OP_ORI      = 5'b01110;
    localparam logic [4:0] c_OP_LD       = 5'b01111;
    localparam logic [4:0] c_OP_ST       = 5'b10000;
    localparam logic [4:0] c_OP_BR       = 5'b10001;
    localparam logic [4:0] c_OP_HALT     = 5'b11011;

    localparam logic [4:0] c_ALU_ADD = 5'b00011;
    localparam logic [4:0] c_ALU_SUB = 5'b00100;
    localparam logic [4:0] c_ALU_AND = 5'b00101;
    localparam logic [4:0] c_ALU_OR  = 5'b00110;

endpackage
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : opcode_decoder
// Brief    : Combinational opcode -> {instruction class, ALU function}.
// Revision : 1.0
// ============================================================================
module opcode_decoder
    import control_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0]  opcode,
    output logic [c_CLASS_W-1:0] op_class,
    output logic [OPCODE_W-1:0]  alu_op
);

    always_comb begin
        op_class = c_CL_NOP;
        alu_op   = '0;
        if (opcode >= OPCODE_W'(c_OP_RTYPE_LO) && opcode <= OPCODE_W'(c_OP_RTYPE_HI)) begin
            op_class = c_CL_RTYPE;
            alu_op   = opcode;
        end else begin
            // Address arithmetic for ld/st/br always uses ADD.
            case (opcode)
                OPCODE_W'(c_OP_ADDI): begin op_class = c_CL_IMM;  alu_op = OPCODE_W'(c_ALU_ADD); end
                OPCODE_W'(c_OP_ANDI): begin op_class = c_CL_IMM;  alu_op = OPCODE_W'(c_ALU_AND); end
                OPCODE_W'(c_OP_ORI):  begin op_class = c_CL_IMM;  alu_op = OPCODE_W'(c_ALU_OR);  end
                OPCODE_W'(c_OP_LD):   begin op_class = c_CL_LD;   alu_op = OPCODE_W'(c_ALU_ADD); end
                OPCODE_W'(c_OP_ST):   begin op_class = c_CL_ST;   alu_op = OPCODE_W'(c_ALU_ADD); end
                OPCODE_W'(c_OP_BR):   begin op_class = c_CL_BR;   alu_op = OPCODE_W'(c_ALU_ADD); end
                OPCODE_W'(c_OP_HALT): begin op_class = c_CL_HALT; end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Hardwired T-state control unit for the single-bus datapath with
//            memory wait-state handshaking, timeout fault and stop request.
// Revision : 1.0
// ============================================================================
module control_sequencer
    import control_pkg::*;
#(
    parameter int IR_W     = 32,
    parameter int OPCODE_W = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [IR_W-1:0]     ir,
    input  logic                con_in,
    input  logic                mem_ready,
    input  logic                stop,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                Zlowout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                GRA,
    output logic                GRB,
    output logic                GRC,
    output logic                Rin,
    output logic                Rout,
    output logic                Cout,
    output logic                RAM_read,
    output logic                RAM_write,
    output logic [OPCODE_W-1:0] opcode,
    output logic [3:0]          tstate,
    output logic                run,
    output logic                fault
);

    localparam int unsigned c_WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

    logic [c_STATE_W-1:0] r_state;
    logic [c_CLASS_W-1:0] r_class;
    logic [OPCODE_W-1:0]  r_alu_op;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic                 r_fault;

    logic [c_CLASS_W-1:0] w_dec_class;
    logic [OPCODE_W-1:0]  w_dec_alu_op;
    logic                 w_mem_state;
    logic [c_STATE_W-1:0] w_done_state;
    logic                 w_unused_ir;

    assign w_unused_ir = ^ir[IR_W-OPCODE_W-1:0];

    opcode_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_opcode_decoder (
        .opcode   (ir[IR_W-1 -: OPCODE_W]),
        .op_class (w_dec_class),
        .alu_op   (w_dec_alu_op)
    );

    assign w_mem_state = (r_state == c_ST_T1) ||
                         (r_state == c_ST_T6 && r_class == c_CL_LD) ||
                         (r_state == c_ST_T7 && r_class == c_CL_ST);

    // Stop is only honoured at an instruction boundary.
    assign w_done_state = stop ? c_ST_HALT : c_ST_T0;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= c_ST_RESET;
            r_class    <= c_CL_NOP;
            r_alu_op   <= '0;
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else if (w_mem_state && !mem_ready) begin
            if (r_wait_cnt == c_WAIT_MAX) begin
                r_state    <= c_ST_HALT;
                r_fault    <= 1'b1;
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
            case (r_state)
                c_ST_RESET: r_state <= c_ST_T0;
                c_ST_T0:    r_state <= c_ST_T1;
                c_ST_T1:    r_state <= c_ST_T2;
                c_ST_T2: begin
                    r_class  <= w_dec_class;
                    r_alu_op <= w_dec_alu_op;
                    if (w_dec_class == c_CL_HALT)     r_state <= c_ST_HALT;
                    else if (w_dec_class == c_CL_NOP) r_state <= w_done_state;
                    else                              r_state <= c_ST_T3;
                end
                c_ST_T3: r_state <= c_ST_T4;
                c_ST_T4: r_state <= c_ST_T5;
                c_ST_T5: begin
                    if (r_class == c_CL_LD || r_class == c_CL_ST) r_state <= c_ST_T6;
                    else                                          r_state <= w_done_state;
                end
                c_ST_T6: r_state <= c_ST_T7;
                c_ST_T7: r_state <= w_done_state;
                default: r_state <= c_ST_HALT;
            endcase
        end
    end

    always_comb begin
        PCout = 1'b0;  MARin = 1'b0;  IncPC = 1'b0;  Zin = 1'b0;
        Zlowout = 1'b0; PCin = 1'b0;  Read = 1'b0;   MDRin = 1'b0;
        MDRout = 1'b0; IRin = 1'b0;   Yin = 1'b0;    GRA = 1'b0;
        GRB = 1'b0;    GRC = 1'b0;    Rin = 1'b0;    Rout = 1'b0;
        Cout = 1'b0;   RAM_read = 1'b0; RAM_write = 1'b0;
        opcode = '0;
        case (r_state)
            c_ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            c_ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; RAM_read = 1'b1; MDRin = 1'b1; end
            c_ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            c_ST_T3: begin
                Yin = 1'b1;
                if (r_class == c_CL_BR) PCout = 1'b1;
                else begin GRB = 1'b1; Rout = 1'b1; end
            end
            c_ST_T4: begin
                Zin    = 1'b1;
                opcode = r_alu_op;
                if (r_class == c_CL_RTYPE) begin GRC = 1'b1; Rout = 1'b1; end
                else Cout = 1'b1;
            end
            c_ST_T5: begin
                if (r_class == c_CL_LD || r_class == c_CL_ST) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (r_class == c_CL_BR) begin
                    Zlowout = con_in; PCin = con_in;
                end else begin
                    Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                end
            end
            c_ST_T6: begin
                MDRin = 1'b1;
                if (r_class == c_CL_LD) begin Read = 1'b1; RAM_read = 1'b1; end
                else begin GRA = 1'b1; Rout = 1'b1; end
            end
            c_ST_T7: begin
                if (r_class == c_CL_LD) begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                else RAM_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign run    = ~r_state[3];
    assign tstate = r_state[3] ? 4'hF : r_state;
    assign fault  = r_fault;

endmodule
`default_nettype wire
